// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - CPU request/response and APB bus bundle for apb_master_bridge
interface apb_master_bridge_if #(
  parameter int unsigned NUM_SLV = 4
);
  // CPU side
  logic                   req;
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic                   we;
  logic [31:0]            rdata;
  logic                   ready;
  logic                   err;
  // APB side
  logic [31:0]            PADDR;
  logic                   PWRITE;
  logic [31:0]            PWDATA;
  logic [NUM_SLV-1:0]     PSEL;
  logic                   PENABLE;
  logic [NUM_SLV*32-1:0]  PRDATA_i;
  logic [NUM_SLV-1:0]     PREADY_i;

  // Bridge side: accepts CPU requests, drives the APB bus
  modport master (
    input  req, addr, wdata, we, PRDATA_i, PREADY_i,
    output rdata, ready, err, PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );

  // Environment side: the requester plus the APB slaves
  modport slave (
    output req, addr, wdata, we, PRDATA_i, PREADY_i,
    input  rdata, ready, err, PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding CPU request to APB master bridge with decode and timeout
module apb_master_bridge #(
  parameter int unsigned NUM_SLV = 4,
  parameter logic [15:0] BASE_HI = 16'h1000,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_master_bridge_if.master bus
);

  localparam int unsigned CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [31:0]          paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [3:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 dec_hit;
  logic [3:0]           dec_idx;
  logic [NUM_SLV-1:0]   dec_sel;
  logic [31:0]          sel_rdata;
  logic                 sel_ready;
  logic                 tmo_hit;

  // Address decode of the incoming request: base window check plus slave slot
  always_comb begin
    dec_idx = bus.addr[15:12];
    dec_hit = (bus.addr[31:16] == BASE_HI) && (32'(dec_idx) < NUM_SLV);
    dec_sel = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      dec_sel[k] = (dec_idx == 4'(k));
    end
  end

  // Return path mux: only the latched slave's PRDATA/PREADY are ever looked at
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (idx_q == 4'(k)) begin
        sel_rdata = bus.PRDATA_i[32*k +: 32];
        sel_ready = bus.PREADY_i[k];
      end
    end
  end

  // Timeout fires on the last permitted ACCESS cycle; TIMEOUT==0 disables it
  always_comb begin
    tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST));
  end

  // Next-state and next-output logic; outputs are registered so every APB pin is glitch-free
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    rdata_d   = rdata_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        if (bus.req) begin
          paddr_d  = bus.addr;
          pwdata_d = bus.wdata;
          pwrite_d = bus.we;
          idx_d    = dec_idx;
          if (dec_hit) begin
            psel_d  = dec_sel;
            state_d = S_SETUP;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (sel_ready) begin
          // A PREADY coinciding with timeout expiry still counts as a normal completion
          rdata_d   = pwrite_q ? 32'h0 : sel_rdata;
          ready_d   = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end else if (tmo_hit) begin
          rdata_d   = 32'h0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ERR: begin
        rdata_d = 32'h0;
        ready_d = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transfer silently
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= 4'h0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  logic PCLK = 1'b0;
  logic PRESET;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.NUM_SLV(4)) bus ();

  apb_master_bridge #(
    .NUM_SLV (4),
    .BASE_HI (16'h1000),
    .TIMEOUT (16)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  // Slave 0: timer peripheral with registered PREADY (one wait state)
  logic [31:0] t_tcr = 32'h0;
  logic [31:0] t_tcnt = 32'h0;
  logic [31:0] t_psc = 32'h0;
  logic [31:0] t_snap = 32'h0;
  logic        t_pready = 1'b0;
  logic [31:0] t_rd;

  always_comb begin
    case (bus.PADDR[3:0])
      4'h0:    t_rd = t_tcr;
      4'h4:    t_rd = t_tcnt;
      4'h8:    t_rd = t_psc;
      default: t_rd = 32'h0;
    endcase
  end

  always @(posedge PCLK) begin
    t_pready <= bus.PSEL[0] && bus.PENABLE && !t_pready;
    if (t_tcr[0]) t_tcnt <= t_tcnt + 32'd1;
    if (bus.PSEL[0] && bus.PENABLE && t_pready) begin
      if (bus.PWRITE) begin
        if (bus.PADDR[3:0] == 4'h0) t_tcr <= bus.PWDATA;
        if (bus.PADDR[3:0] == 4'h8) t_psc <= bus.PWDATA;
      end else begin
        t_snap <= t_rd;
      end
    end
  end

  // Slave 1: zero-wait, echoes low address bits; slave 2: never ready; slave 3: zero-wait constant
  logic [31:0] s1_rd;
  assign s1_rd        = 32'h1111_0000 | {20'h0, bus.PADDR[11:0]};
  assign bus.PREADY_i = {1'b1, 1'b0, 1'b1, t_pready};
  assign bus.PRDATA_i = {32'h3333_3333, 32'hDEAD_BEEF, s1_rd, t_rd};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge, let one edge accept it, then drop req; returns in cycle 1
  task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic w);
    bus.req   = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = w;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.req = 1'b0;
  endtask

  // From cycle 1, step until ready; reports the ready cycle and activity seen before it
  task automatic run_to_ready(input int bound, output int cyc, output logic [3:0] psel_or,
                              output int pen_cnt);
    cyc     = 1;
    psel_or = 4'h0;
    pen_cnt = 0;
    while (!bus.ready && cyc < bound) begin
      psel_or |= bus.PSEL;
      pen_cnt += int'(bus.PENABLE);
      @(negedge PCLK);
      cyc++;
    end
    if (!bus.ready) chk("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input int exp_cyc, input logic [31:0] exp_rd,
                      input logic exp_err);
    int         cyc;
    int         pen;
    logic [3:0] ps;
    start_req(a, d, w);
    run_to_ready(40, cyc, ps, pen);
    chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, "_rdata"}, bus.rdata, exp_rd);
    @(negedge PCLK);
    chk({tag, "_pulse"}, 32'(bus.ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         cyc;
    int         pen;
    logic [3:0] ps;
    logic [31:0] ba [3];

    bus.req   = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.we    = 1'b0;
    PRESET    = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);

    chk("rst_psel", 32'(bus.PSEL), 32'h0);
    chk("rst_penable", 32'(bus.PENABLE), 32'h0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Write timer PSC, cycle by cycle
    start_req(32'h1000_0008, 32'd99, 1'b1);
    chk("psc_c1_psel", 32'(bus.PSEL), 32'h1);
    chk("psc_c1_penable", 32'(bus.PENABLE), 32'h0);
    chk("psc_c1_paddr", bus.PADDR, 32'h1000_0008);
    chk("psc_c1_pwdata", bus.PWDATA, 32'd99);
    chk("psc_c1_pwrite", 32'(bus.PWRITE), 32'h1);
    @(negedge PCLK);
    chk("psc_c2_psel", 32'(bus.PSEL), 32'h1);
    chk("psc_c2_penable", 32'(bus.PENABLE), 32'h1);
    chk("psc_c2_paddr", bus.PADDR, 32'h1000_0008);
    chk("psc_c2_ready", 32'(bus.ready), 32'h0);
    @(negedge PCLK);
    chk("psc_c3_penable", 32'(bus.PENABLE), 32'h1);
    chk("psc_c3_pwdata", bus.PWDATA, 32'd99);
    chk("psc_c3_ready", 32'(bus.ready), 32'h0);
    @(negedge PCLK);
    chk("psc_c4_ready", 32'(bus.ready), 32'h1);
    chk("psc_c4_err", 32'(bus.err), 32'h0);
    chk("psc_c4_psel", 32'(bus.PSEL), 32'h0);
    chk("psc_reg", t_psc, 32'd99);
    @(negedge PCLK);
    chk("psc_c5_ready", 32'(bus.ready), 32'h0);

    // Readback PSC, enable the timer, then read a running tcnt
    xfer("psc_rd", 32'h1000_0008, 32'h0, 1'b0, 4, 32'd99, 1'b0);
    xfer("tcr_wr", 32'h1000_0000, 32'd1, 1'b1, 4, 32'h0, 1'b0);
    repeat (5) @(negedge PCLK);
    start_req(32'h1000_0004, 32'h0, 1'b0);
    run_to_ready(40, cyc, ps, pen);
    chk("tcnt_cyc", 32'(cyc), 32'd4);
    chk("tcnt_err", 32'(bus.err), 32'h0);
    chk("tcnt_rdata", bus.rdata, t_snap);
    chk("tcnt_nonzero", 32'(bus.rdata != 32'h0), 32'h1);
    @(negedge PCLK);

    // Decode misses: outside base window, then slot beyond NUM_SLV
    start_req(32'h2000_0004, 32'h0, 1'b0);
    run_to_ready(40, cyc, ps, pen);
    chk("miss1_cyc", 32'(cyc), 32'd2);
    chk("miss1_psel_before", 32'(ps), 32'h0);
    chk("miss1_psel_ready", 32'(bus.PSEL), 32'h0);
    chk("miss1_err", 32'(bus.err), 32'h1);
    chk("miss1_rdata", bus.rdata, 32'h0);
    @(negedge PCLK);
    xfer("s3_rd", 32'h1000_3000, 32'h0, 1'b0, 3, 32'h3333_3333, 1'b0);
    start_req(32'h1000_4000, 32'h0, 1'b0);
    run_to_ready(40, cyc, ps, pen);
    chk("miss2_cyc", 32'(cyc), 32'd2);
    chk("miss2_psel_before", 32'(ps), 32'h0);
    chk("miss2_err", 32'(bus.err), 32'h1);
    chk("miss2_rdata", bus.rdata, 32'h0);
    @(negedge PCLK);

    // Timeout on slave 2 (PREADY tied low)
    xfer("s3_rd2", 32'h1000_3004, 32'h0, 1'b0, 3, 32'h3333_3333, 1'b0);
    start_req(32'h1000_2000, 32'h0, 1'b0);
    run_to_ready(60, cyc, ps, pen);
    chk("tmo_cyc", 32'(cyc), 32'd18);
    chk("tmo_access_len", 32'(pen), 32'd16);
    chk("tmo_psel_seen", 32'(ps), 32'h4);
    chk("tmo_err", 32'(bus.err), 32'h1);
    chk("tmo_rdata", bus.rdata, 32'h0);
    chk("tmo_psel_drop", 32'(bus.PSEL), 32'h0);
    chk("tmo_penable_drop", 32'(bus.PENABLE), 32'h0);
    @(negedge PCLK);

    // Back-to-back reads on zero-wait slave 1, req held high
    ba[0] = 32'h1000_1004;
    ba[1] = 32'h1000_1008;
    ba[2] = 32'h1000_100C;
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = ba[0];
    for (int i = 0; i < 3; i++) begin
      cyc = 0;
      ps  = 4'hF;
      while (cyc < 10) begin
        @(negedge PCLK);
        cyc++;
        if (bus.ready) break;
        ps &= bus.PSEL;
      end
      chk($sformatf("b2b%0d_len", i), 32'(cyc), 32'd3);
      chk($sformatf("b2b%0d_psel_busy", i), 32'(ps[1]), 32'h1);
      chk($sformatf("b2b%0d_psel_gap", i), 32'(bus.PSEL[1]), 32'h0);
      chk($sformatf("b2b%0d_rdata", i), bus.rdata, 32'h1111_0000 | {20'h0, ba[i][11:0]});
      chk($sformatf("b2b%0d_err", i), 32'(bus.err), 32'h0);
      if (i < 2) bus.addr = ba[i+1];
      else bus.req = 1'b0;
    end
    @(negedge PCLK);
    chk("b2b_end_psel", 32'(bus.PSEL), 32'h0);

    // Reset while a transfer sits in ACCESS
    start_req(32'h1000_2004, 32'h0, 1'b0);
    @(negedge PCLK);
    chk("rmid_in_access", 32'(bus.PENABLE), 32'h1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("rmid_psel", 32'(bus.PSEL), 32'h0);
    chk("rmid_penable", 32'(bus.PENABLE), 32'h0);
    chk("rmid_ready", 32'(bus.ready), 32'h0);
    chk("rmid_err", 32'(bus.err), 32'h0);
    chk("rmid_rdata", bus.rdata, 32'h0);
    repeat (3) begin
      @(negedge PCLK);
      chk("rmid_no_resp", 32'(bus.ready), 32'h0);
    end
    xfer("rmid_after", 32'h1000_3008, 32'h0, 1'b0, 3, 32'h3333_3333, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
